// File: rtl/fp_writeback_queue.sv
// -----------------------------------------------------------------------------
// fp_writeback_queue
//
// Selects one of NUM_SRC result sources, tags it with a destination register
// and FP/INT write enables, buffers it in a DEPTH-entry FIFO, and drains the
// FIFO into the FP and INT register-file write ports through registered
// outputs. When SHARED_PORT is set, an entry that writes both register files
// is issued over two cycles: the FP write first, then the INT write.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   src_data   in   packed sources, source i at [i*XLEN +: XLEN]
//   wb_sel     in   source select; values >= NUM_SRC select zero
//   wb_fp_en   in   entry writes the FP register file
//   wb_int_en  in   entry writes the INT register file (ignored when rd == 0)
//   rd         in   destination register
//   in_valid   in   upstream offers an entry
//   in_ready   out  queue can accept an entry this cycle
//   rf_stall   in   register-file ports busy; nothing issues this cycle
//   fp_we      out  FP write strobe (one cycle per issue)
//   fp_waddr   out  FP write address
//   fp_wdata   out  FP write data
//   int_we     out  INT write strobe (one cycle per issue)
//   int_waddr  out  INT write address
//   int_wdata  out  INT write data
//   pend_count out  number of queued entries
//   busy       out  queue non-empty or a split dual write is in flight
// -----------------------------------------------------------------------------
module fp_writeback_queue #(
  parameter int XLEN        = 32,
  parameter int NUM_SRC     = 4,
  parameter int SEL_W       = $clog2(NUM_SRC),
  parameter int DEPTH       = 4,
  parameter bit SHARED_PORT = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*XLEN-1:0]  src_data,
  input  logic [SEL_W-1:0]         wb_sel,
  input  logic                     wb_fp_en,
  input  logic                     wb_int_en,
  input  logic [4:0]               rd,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     rf_stall,
  output logic                     fp_we,
  output logic [4:0]               fp_waddr,
  output logic [XLEN-1:0]          fp_wdata,
  output logic                     int_we,
  output logic [4:0]               int_waddr,
  output logic [XLEN-1:0]          int_wdata,
  output logic [$clog2(DEPTH):0]   pend_count,
  output logic                     busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // IDLE: head issues normally. INT_PEND: FP half of a dual write has gone
  // out, the head is still queued and waits for its INT write.
  typedef enum logic {
    IDLE     = 1'b0,
    INT_PEND = 1'b1
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic            fp_en;
    logic            int_en;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  state_t           state;

  logic [XLEN-1:0]  sel_data;
  logic             int_en_eff;
  logic             push;
  logic             pop;
  logic             can_issue;
  logic             split;
  entry_t           head;

  // ---------------------------------------------------------------------------
  // Source mux, evaluated at acceptance time.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: assign a default before any conditional assignment so every path
    // drives the signal and no latch is inferred.
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (int'(wb_sel) == i) begin
        sel_data = src_data[i*XLEN +: XLEN];
      end
    end
  end

  // x0 is hard-wired to zero, so an INT write to it is dropped at the door.
  assign int_en_eff = wb_int_en && (rd != 5'd0);

  // in_ready depends only on registered occupancy: a pop in the same cycle
  // does not make room, which keeps the upstream handshake off the stall path.
  assign in_ready = !rst && (count < CNT_W'(DEPTH));

  // Entries with no remaining write enable are handshaken but never stored.
  assign push = in_valid && in_ready && (wb_fp_en || int_en_eff);

  assign head      = mem[rd_ptr];
  assign can_issue = !rf_stall && (count != '0);
  assign split     = SHARED_PORT && head.fp_en && head.int_en;

  // The head leaves the queue on every issue except the FP half of a split.
  always_comb begin
    pop = 1'b0;
    if (can_issue) begin
      pop = (state == INT_PEND) || !split;
    end
  end

  // ---------------------------------------------------------------------------
  // Queue storage.
  // ---------------------------------------------------------------------------
  // NOTE: storage has no reset; an entry is only ever read after it has been
  // written, and the pointers/count (which are reset) define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{data: sel_data, rd: rd, fp_en: wb_fp_en, int_en: int_en_eff};
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, occupancy, issue FSM and registered write ports.
  // ---------------------------------------------------------------------------
  // NOTE: every register here uses non-blocking assignments so all of them
  // update together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      state     <= IDLE;
      fp_we     <= 1'b0;
      fp_waddr  <= '0;
      fp_wdata  <= '0;
      int_we    <= 1'b0;
      int_waddr <= '0;
      int_wdata <= '0;
    end else begin
      // DEPTH is a power of two, so the natural pointer overflow is the wrap.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // Strobes are single-cycle; address/data hold when nothing issues.
      fp_we  <= 1'b0;
      int_we <= 1'b0;

      if (can_issue) begin
        case (state)
          INT_PEND: begin
            int_we    <= 1'b1;
            int_waddr <= head.rd;
            int_wdata <= head.data;
            state     <= IDLE;
          end
          default: begin
            if (split) begin
              fp_we    <= 1'b1;
              fp_waddr <= head.rd;
              fp_wdata <= head.data;
              state    <= INT_PEND;
            end else begin
              fp_we     <= head.fp_en;
              int_we    <= head.int_en;
              fp_waddr  <= head.rd;
              int_waddr <= head.rd;
              fp_wdata  <= head.fp_en  ? head.data : '0;
              int_wdata <= head.int_en ? head.data : '0;
            end
          end
        endcase
      end
    end
  end

  assign pend_count = count;
  assign busy       = (count != '0) || (state != IDLE);

endmodule

// File: tb/tb_fp_writeback_queue.sv
// -----------------------------------------------------------------------------
// tb_fp_writeback_queue
//
// Two instances: dut_a uses the defaults (NUM_SRC = 4, SHARED_PORT = 0),
// dut_b uses NUM_SRC = 3 with SHARED_PORT = 1. Each has a scoreboard queue of
// expected write events, pushed when an entry is accepted and popped by a
// negedge monitor whenever a write strobe is seen. Cycle-exact behaviour is
// checked directly by the stimulus thread.
// -----------------------------------------------------------------------------
module tb_fp_writeback_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] src_data;
  logic [1:0]   wb_sel;
  logic         wb_fp_en;
  logic         wb_int_en;
  logic [4:0]   rd;
  logic         in_valid_a;
  logic         in_valid_b;
  logic         rf_stall;

  logic         in_ready_a, fp_we_a, int_we_a, busy_a;
  logic [4:0]   fp_waddr_a, int_waddr_a;
  logic [31:0]  fp_wdata_a, int_wdata_a;
  logic [2:0]   pend_count_a;

  logic         in_ready_b, fp_we_b, int_we_b, busy_b;
  logic [4:0]   fp_waddr_b, int_waddr_b;
  logic [31:0]  fp_wdata_b, int_wdata_b;
  logic [2:0]   pend_count_b;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        fp;
    logic        intw;
    logic [4:0]  addr;
    logic [31:0] fdata;
    logic [31:0] idata;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t mon_a;
  exp_t mon_b;

  typedef struct {
    logic [1:0]  sel;
    logic [4:0]  r;
    logic        f;
    logic        i;
    logic        exp_fp;
    logic        exp_int;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  fp_writeback_queue dut_a (
    .clk        (clk),
    .rst        (rst),
    .src_data   (src_data),
    .wb_sel     (wb_sel),
    .wb_fp_en   (wb_fp_en),
    .wb_int_en  (wb_int_en),
    .rd         (rd),
    .in_valid   (in_valid_a),
    .in_ready   (in_ready_a),
    .rf_stall   (rf_stall),
    .fp_we      (fp_we_a),
    .fp_waddr   (fp_waddr_a),
    .fp_wdata   (fp_wdata_a),
    .int_we     (int_we_a),
    .int_waddr  (int_waddr_a),
    .int_wdata  (int_wdata_a),
    .pend_count (pend_count_a),
    .busy       (busy_a)
  );

  fp_writeback_queue #(
    .NUM_SRC     (3),
    .SHARED_PORT (1'b1)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .src_data   (src_data[95:0]),
    .wb_sel     (wb_sel),
    .wb_fp_en   (wb_fp_en),
    .wb_int_en  (wb_int_en),
    .rd         (rd),
    .in_valid   (in_valid_b),
    .in_ready   (in_ready_b),
    .rf_stall   (rf_stall),
    .fp_we      (fp_we_b),
    .fp_waddr   (fp_waddr_b),
    .fp_wdata   (fp_wdata_b),
    .int_we     (int_we_b),
    .int_waddr  (int_waddr_b),
    .int_wdata  (int_wdata_b),
    .pend_count (pend_count_b),
    .busy       (busy_b)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] s, input logic [4:0] r, input logic f, input logic i);
    wb_sel    = s;
    rd        = r;
    wb_fp_en  = f;
    wb_int_en = i;
  endtask

  function automatic logic [31:0] src_word(input int s, input int n);
    if (s >= n) return '0;
    return src_data[s*32 +: 32];
  endfunction

  // Expected events for the non-shared instance: one event per stored entry.
  task automatic push_model_a();
    exp_t        e;
    logic        ie;
    logic [31:0] d;
    d  = src_word(int'(wb_sel), 4);
    ie = wb_int_en && (rd != 5'd0);
    if (wb_fp_en || ie) begin
      e.fp    = wb_fp_en;
      e.intw  = ie;
      e.addr  = rd;
      e.fdata = wb_fp_en ? d : '0;
      e.idata = ie ? d : '0;
      sb_a.push_back(e);
    end
  endtask

  // Expected events for the shared-port instance: dual writes become two.
  task automatic push_model_b();
    exp_t        e;
    logic        ie;
    logic [31:0] d;
    d  = src_word(int'(wb_sel), 3);
    ie = wb_int_en && (rd != 5'd0);
    e.addr = rd;
    if (wb_fp_en && ie) begin
      e.fp = 1'b1; e.intw = 1'b0; e.fdata = d;   e.idata = '0;
      sb_b.push_back(e);
      e.fp = 1'b0; e.intw = 1'b1; e.fdata = '0;  e.idata = d;
      sb_b.push_back(e);
    end else if (wb_fp_en || ie) begin
      e.fp    = wb_fp_en;
      e.intw  = ie;
      e.fdata = wb_fp_en ? d : '0;
      e.idata = ie ? d : '0;
      sb_b.push_back(e);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitors
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (fp_we_a || int_we_a) begin
      if (sb_a.size() == 0) begin
        check_b("a_unexpected_strobe", fp_we_a | int_we_a, 1'b0);
      end else begin
        mon_a = sb_a.pop_front();
        check_b("a_sb_fp_we",  fp_we_a,  mon_a.fp);
        check_b("a_sb_int_we", int_we_a, mon_a.intw);
        check("a_sb_fp_waddr",  32'(fp_waddr_a),  32'(mon_a.addr));
        check("a_sb_int_waddr", 32'(int_waddr_a), 32'(mon_a.addr));
        check("a_sb_fp_wdata",  fp_wdata_a,  mon_a.fdata);
        check("a_sb_int_wdata", int_wdata_a, mon_a.idata);
      end
    end
    if (fp_we_b || int_we_b) begin
      if (sb_b.size() == 0) begin
        check_b("b_unexpected_strobe", fp_we_b | int_we_b, 1'b0);
      end else begin
        mon_b = sb_b.pop_front();
        check_b("b_sb_fp_we",  fp_we_b,  mon_b.fp);
        check_b("b_sb_int_we", int_we_b, mon_b.intw);
        if (mon_b.fp) begin
          check("b_sb_fp_waddr", 32'(fp_waddr_b), 32'(mon_b.addr));
          check("b_sb_fp_wdata", fp_wdata_b, mon_b.fdata);
        end
        if (mon_b.intw) begin
          check("b_sb_int_waddr", 32'(int_waddr_b), 32'(mon_b.addr));
          check("b_sb_int_wdata", int_wdata_b, mon_b.idata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    //            sel    rd     f     i     efp   eint  data
    vecs[0] = '{2'd0, 5'd3,  1'b1, 1'b1, 1'b1, 1'b1, 32'h3F800000};
    vecs[1] = '{2'd1, 5'd4,  1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678};
    vecs[2] = '{2'd2, 5'd6,  1'b1, 1'b0, 1'b1, 1'b0, 32'hCCCC0002};
    vecs[3] = '{2'd3, 5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 32'hDDDD0003};
    vecs[4] = '{2'd1, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000};
    vecs[5] = '{2'd2, 5'd31, 1'b0, 1'b1, 1'b0, 1'b1, 32'hCCCC0002};

    src_data   = {32'hDDDD0003, 32'hCCCC0002, 32'h12345678, 32'h3F800000};
    rst        = 1'b1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    rf_stall   = 1'b0;
    drive(2'd0, 5'd0, 1'b0, 1'b0);

    // ---- reset state ----
    tick();
    tick();
    check_b("rst_in_ready_a", in_ready_a, 1'b0);
    check_b("rst_fp_we_a",    fp_we_a,    1'b0);
    check_b("rst_int_we_a",   int_we_a,   1'b0);
    check("rst_pend_a",       32'(pend_count_a), 32'd0);
    check_b("rst_busy_a",     busy_a,     1'b0);
    check_b("rst_busy_b",     busy_b,     1'b0);
    check("rst_fp_wdata_a",   fp_wdata_a, 32'd0);
    rst = 1'b0;
    #1;
    check_b("post_rst_in_ready_a", in_ready_a, 1'b1);
    check_b("post_rst_in_ready_b", in_ready_b, 1'b1);

    // ---- single FP write ----
    drive(2'd0, 5'd5, 1'b1, 1'b0);
    in_valid_a = 1'b1;
    push_model_a();
    tick();
    in_valid_a = 1'b0;
    check_b("single_no_bypass", fp_we_a, 1'b0);
    check("single_pend", 32'(pend_count_a), 32'd1);
    tick();
    check_b("single_fp_we", fp_we_a, 1'b1);
    check("single_fp_waddr", 32'(fp_waddr_a), 32'd5);
    check("single_fp_wdata", fp_wdata_a, 32'h3F800000);
    check_b("single_int_we", int_we_a, 1'b0);
    tick();
    check_b("single_fp_we_one_cycle", fp_we_a, 1'b0);
    check_b("single_idle", busy_a, 1'b0);

    // ---- table-driven single entries ----
    for (int v = 0; v < 6; v++) begin
      drive(vecs[v].sel, vecs[v].r, vecs[v].f, vecs[v].i);
      in_valid_a = 1'b1;
      push_model_a();
      tick();
      in_valid_a = 1'b0;
      check($sformatf("vec%0d_pend", v), 32'(pend_count_a),
            32'(vecs[v].exp_fp | vecs[v].exp_int));
      tick();
      check_b($sformatf("vec%0d_fp_we", v),  fp_we_a,  vecs[v].exp_fp);
      check_b($sformatf("vec%0d_int_we", v), int_we_a, vecs[v].exp_int);
      if (vecs[v].exp_fp)  check($sformatf("vec%0d_fp_wdata", v),  fp_wdata_a,  vecs[v].exp_data);
      if (vecs[v].exp_int) check($sformatf("vec%0d_int_wdata", v), int_wdata_a, vecs[v].exp_data);
      check($sformatf("vec%0d_pend_after", v), 32'(pend_count_a), 32'd0);
    end
    tick();

    // ---- fill, block, drain with full-queue push/pop ----
    rf_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(2'(i), 5'(10 + i), 1'b1, (i % 2) == 1);
      in_valid_a = 1'b1;
      push_model_a();
      tick();
    end
    check_b("fill_in_ready_low", in_ready_a, 1'b0);
    check("fill_pend_full", 32'(pend_count_a), 32'd4);
    drive(2'd1, 5'd14, 1'b1, 1'b1);
    tick();
    check("fill_fifth_held_pend", 32'(pend_count_a), 32'd4);
    check_b("fill_fifth_held_ready", in_ready_a, 1'b0);
    check_b("fill_stalled_no_we", fp_we_a, 1'b0);
    rf_stall = 1'b0;
    tick();
    check_b("drain0_fp_we", fp_we_a, 1'b1);
    check("drain0_pend", 32'(pend_count_a), 32'd3);
    check_b("drain0_ready_rises", in_ready_a, 1'b1);
    push_model_a();
    tick();
    in_valid_a = 1'b0;
    check_b("drain1_fp_we", fp_we_a, 1'b1);
    check("drain1_pushpop_pend", 32'(pend_count_a), 32'd3);
    for (int i = 2; i < 5; i++) begin
      tick();
      check_b($sformatf("drain%0d_fp_we", i), fp_we_a, 1'b1);
      check($sformatf("drain%0d_pend", i), 32'(pend_count_a), 32'(4 - i));
      check_b($sformatf("drain%0d_pend_le_depth", i), pend_count_a <= 3'd4, 1'b1);
    end
    tick();
    check_b("drain_done_fp_we", fp_we_a, 1'b0);
    check_b("drain_done_busy", busy_a, 1'b0);

    // ---- reset mid-drain ----
    rf_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(2'(i), 5'(20 + i), 1'b1, 1'b0);
      in_valid_a = 1'b1;
      push_model_a();
      tick();
    end
    in_valid_a = 1'b0;
    check("middrain_pend", 32'(pend_count_a), 32'd3);
    rf_stall = 1'b0;
    tick();
    check_b("middrain_first_we", fp_we_a, 1'b1);
    rst = 1'b1;
    tick();
    sb_a.delete();
    check_b("middrain_rst_fp_we",  fp_we_a,  1'b0);
    check_b("middrain_rst_int_we", int_we_a, 1'b0);
    check("middrain_rst_pend",     32'(pend_count_a), 32'd0);
    check_b("middrain_rst_busy",   busy_a,   1'b0);
    check_b("middrain_rst_ready",  in_ready_a, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_b($sformatf("middrain_stale%0d", i), fp_we_a | int_we_a, 1'b0);
    end

    // ---- shared port: out-of-range select ----
    drive(2'd3, 5'd9, 1'b1, 1'b0);
    in_valid_b = 1'b1;
    push_model_b();
    tick();
    in_valid_b = 1'b0;
    tick();
    check_b("oor_fp_we", fp_we_b, 1'b1);
    check("oor_fp_wdata", fp_wdata_b, 32'd0);
    check("oor_fp_waddr", 32'(fp_waddr_b), 32'd9);
    tick();

    // ---- shared port: dual write ----
    drive(2'd1, 5'd7, 1'b1, 1'b1);
    in_valid_b = 1'b1;
    push_model_b();
    tick();
    in_valid_b = 1'b0;
    check_b("dual_no_bypass", fp_we_b, 1'b0);
    tick();
    check_b("dual_k1_fp_we",  fp_we_b,  1'b1);
    check_b("dual_k1_int_we", int_we_b, 1'b0);
    check("dual_k1_fp_waddr", 32'(fp_waddr_b), 32'd7);
    check("dual_k1_fp_wdata", fp_wdata_b, 32'h12345678);
    check("dual_k1_pend", 32'(pend_count_b), 32'd1);
    check_b("dual_k1_busy", busy_b, 1'b1);
    tick();
    check_b("dual_k2_fp_we",  fp_we_b,  1'b0);
    check_b("dual_k2_int_we", int_we_b, 1'b1);
    check("dual_k2_int_waddr", 32'(int_waddr_b), 32'd7);
    check("dual_k2_int_wdata", int_wdata_b, 32'h12345678);
    check("dual_k2_pend", 32'(pend_count_b), 32'd0);
    tick();
    check_b("dual_done_int_we", int_we_b, 1'b0);
    check_b("dual_done_busy", busy_b, 1'b0);

    // ---- shared port: stall between the two halves ----
    drive(2'd2, 5'd8, 1'b1, 1'b1);
    in_valid_b = 1'b1;
    push_model_b();
    tick();
    in_valid_b = 1'b0;
    tick();
    check_b("dstall_fp_we", fp_we_b, 1'b1);
    rf_stall = 1'b1;
    tick();
    check_b("dstall_held_int_we", int_we_b, 1'b0);
    check_b("dstall_held_fp_we",  fp_we_b,  1'b0);
    check_b("dstall_held_busy",   busy_b,   1'b1);
    rf_stall = 1'b0;
    tick();
    check_b("dstall_int_we", int_we_b, 1'b1);
    check("dstall_int_waddr", 32'(int_waddr_b), 32'd8);
    check("dstall_int_wdata", int_wdata_b, 32'hCCCC0002);
    tick();
    check_b("dstall_done", int_we_b, 1'b0);

    // ---- shared port: reset discards half-issued dual write ----
    drive(2'd0, 5'd12, 1'b1, 1'b1);
    in_valid_b = 1'b1;
    push_model_b();
    tick();
    in_valid_b = 1'b0;
    tick();
    check_b("drst_fp_we", fp_we_b, 1'b1);
    rst = 1'b1;
    tick();
    sb_b.delete();
    rst = 1'b0;
    check("drst_pend", 32'(pend_count_b), 32'd0);
    check_b("drst_busy", busy_b, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_b($sformatf("drst_stale%0d", i), fp_we_b | int_we_b, 1'b0);
    end

    check("sb_a_drained", 32'(sb_a.size()), 32'd0);
    check("sb_b_drained", 32'(sb_b.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_writeback_queue.md
Name: fp_writeback_queue

Overview:
- Parametrised successor to the FP writeback mux.
- Selects one of NUM_SRC result sources, tags the result with a destination register and FP/INT enables, and buffers it in a DEPTH-entry queue.
- Drains the queue into the FP and INT register-file write ports through registered outputs.
- Provides a valid/ready handshake upstream, a stall input from the register files, and optional shared-write-port serialisation.

Parameters:
- XLEN, 32, data width of every source and write port.
- NUM_SRC, 4, number of result sources (index 0 = FLW data memory, 1 = MOV, 2 = convert/normalise, others free).
- SEL_W, $clog2(NUM_SRC), width of wb_sel (derived, not overridden).
- DEPTH, 4, queue entries; power of two, ≥2.
- SHARED_PORT, 0, 1 = FP and INT writes share one port slot, so dual writes take two issue cycles.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- src_data  in  NUM_SRC*XLEN  packed sources; source i at [i*XLEN +: XLEN]
- wb_sel  in  SEL_W  source select
- wb_fp_en  in  1  entry writes the FP register file
- wb_int_en  in  1  entry writes the INT register file
- rd  in  5  destination register
- in_valid  in  1  upstream offers an entry
- in_ready  out  1  queue can accept an entry
- rf_stall  in  1  register-file ports busy; no issue this cycle
- fp_we  out  1  FP write strobe
- fp_waddr  out  5  FP write address
- fp_wdata  out  XLEN  FP write data
- int_we  out  1  INT write strobe
- int_waddr  out  5  INT write address
- int_wdata  out  XLEN  INT write data
- pend_count  out  $clog2(DEPTH)+1  number of queued entries
- busy  out  1  queue non-empty or FSM not in IDLE

Behaviour:
- **Reset:** while rst is high at an edge, the queue empties, FSM goes to IDLE, and every output register clears (we, waddr, wdata, pend_count = 0, busy = 0). Reset mid-drain discards all pending entries and any half-issued dual write. in_ready = 0 during the reset cycle and 1 afterwards.
- **Accept:** an entry is accepted when in_valid && in_ready at an edge. The mux is evaluated at acceptance. wb_sel ≥ NUM_SRC yields data 0.
- **Queue entry:** {data, rd, fp_en, int_en}.
  - int_en is cleared at acceptance when rd == 0 (x0 is never written).
  - If fp_en and int_en are both 0 after this, the entry is accepted but not queued.
- **in_ready:** = (pend_count < DEPTH), a registered-state function only; no same-cycle pop credit.
- **Simultaneous push and pop:** pend_count is unchanged.
- **Pointer wrap:** read and write pointers wrap modulo DEPTH. Full/empty are resolved by an extra pointer bit or a counter.
- **Issue:** at an edge with rf_stall low and the queue non-empty, the output registers load from the head entry.
  - fp_we = fp_en, int_we = int_en.
  - Both waddrs = rd; both wdatas = data, or 0 on a port whose enable is 0.
  - The strobes are high for exactly one cycle per issue.
- **Stall or empty:** at an edge with rf_stall high or the queue empty, fp_we = int_we = 0 and the waddr/wdata registers hold their previous values.
- **Latency:** entry accepted at edge k → earliest strobe high in cycle k+1 (loaded at edge k+1), with no bypass around the queue. Order is strictly FIFO.
- **SHARED_PORT = 0:** one FSM state, IDLE. The head pops on every issue.
- **SHARED_PORT = 1:** FSM states are IDLE and INT_PEND.
  - From IDLE, a head with both enables issues the FP write only (int_we = 0), does not pop, and goes to INT_PEND.
  - In INT_PEND, the next non-stalled edge issues the INT write, pops the head, and returns to IDLE.
  - rf_stall in INT_PEND holds the state.
  - Single-enable heads issue and pop directly from IDLE.
- **busy:** = (pend_count != 0) || (state != IDLE).

Test Plan:
- **Single FP write:** reset, then one entry (wb_sel = 0, src0 = 0x3F800000, rd = 5, fp_en = 1) → fp_we high exactly one cycle after acceptance, fp_waddr = 5, fp_wdata = 0x3F800000, int_we = 0.
- **Fill, block, drain:** rf_stall held high, push 5 entries back-to-back with DEPTH = 4 → in_ready = 0 after the 4th, pend_count = 4, 5th held. Release the stall → 4 strobes on consecutive cycles in push order, then the 5th.
- **x0 and dead entries:** rd = 0 with int_en only → accepted, nothing queued, no strobe, pend_count stays 0. Out-of-range wb_sel = 3 with NUM_SRC = 3 → wdata = 0.
- **SHARED_PORT = 1 dual write:** dual-enable entry, rd = 7, data 0x12345678 → fp_we in cycle k+1, int_we in cycle k+2, both addr 7. A stall pulse between the two delays int_we by one cycle.
- **Full-queue push/pop:** queue full, in_valid high, rf_stall low → a pop occurs, in_ready rises the following cycle, and pend_count stays at most DEPTH throughout.
- **Reset mid-drain:** 3 entries queued, rst asserted for one cycle → next cycle all we = 0, pend_count = 0, busy = 0, and no stale strobe afterwards.
